// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead slice per stage, valid/ready with global stall.
// Optional build macro CLA_SATURATE_EN clamps overflowing results to the signed limit in the final stage.

module pipelined_cla_addsub_slice #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] i_a,
   input  logic [GROUP-1:0] i_b,
   input  logic             i_ci,
   output logic [GROUP-1:0] o_s,
   output logic             o_pg,
   output logic             o_gg
);
   logic [GROUP-1:0] w_p;
   logic [GROUP-1:0] w_g;
   logic [GROUP-1:0] w_c;
   logic             w_ct;
   logic             w_cpr;
   logic             w_gt;
   logic             w_gpr;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Each internal carry is a flat sum of products over g/p/ci, not a ripple chain.
   always_comb begin
      w_c    = '0;
      w_ct   = 1'b0;
      w_cpr  = 1'b0;
      w_c[0] = i_ci;
      for (int j = 1; j < GROUP; j++) begin
         w_ct = i_ci;
         for (int i = 0; i < j; i++) w_ct = w_ct & w_p[i];
         for (int i = 0; i < j; i++) begin
            w_cpr = w_g[i];
            for (int m = i + 1; m < j; m++) w_cpr = w_cpr & w_p[m];
            w_ct = w_ct | w_cpr;
         end
         w_c[j] = w_ct;
      end
   end

   always_comb begin
      w_gt  = 1'b0;
      w_gpr = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
         w_gpr = w_g[i];
         for (int m = i + 1; m < GROUP; m++) w_gpr = w_gpr & w_p[m];
         w_gt = w_gt | w_gpr;
      end
   end

   assign o_s  = w_p ^ w_c;
   assign o_pg = &w_p;
   assign o_gg = w_gt;
endmodule

module pipelined_cla_addsub #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             ci_i,
   input  logic             sub_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             co_o,
   output logic             ovf_o,
   output logic             zero_o
);
   localparam int S = WIDTH / GROUP;

   // B operand storage is triangular: stage k keeps only bits [WIDTH-1:k*GROUP], packed back to back.
   function automatic int boff(input int k);
      return k * WIDTH - (GROUP * k * (k - 1)) / 2;
   endfunction

   localparam int BT = boff(S);

   logic [S:0]                  r_vld_pipe;
   logic [S-1:0][WIDTH-1:0]     r_as;        // low k*GROUP bits: finished sums, upper bits: operand A
   logic [BT-1:0]               r_bt;
   logic [S-1:0]                r_c;
   logic [WIDTH-1:0]            r_sum;
   logic                        r_co;
   logic                        r_ovf;
   logic                        r_zero;

   logic                        w_adv;
   logic [S-1:0][GROUP-1:0]     w_sl_a;
   logic [S-1:0][GROUP-1:0]     w_sl_b;
   logic [S-1:0][GROUP-1:0]     w_sl_s;
   logic [S-1:0]                w_pg;
   logic [S-1:0]                w_gg;
   logic [S-1:0]                w_co;
   logic [WIDTH-1:0]            w_sum_raw;
   logic [WIDTH-1:0]            w_sum;
   logic                        w_a_msb;
   logic                        w_b_msb;
   logic                        w_ovf;

   assign w_adv   = ~r_vld_pipe[S] | ready_i;
   assign ready_o = w_adv;
   assign valid_o = r_vld_pipe[S];
   assign sum_o   = r_sum;
   assign co_o    = r_co;
   assign ovf_o   = r_ovf;
   assign zero_o  = r_zero;

   for (genvar k = 0; k < S; k++) begin : g_slice
      assign w_sl_a[k] = r_as[k][k*GROUP +: GROUP];
      assign w_sl_b[k] = r_bt[boff(k) +: GROUP];

      pipelined_cla_addsub_slice #(.GROUP(GROUP)) u_slice (
         .i_a  (w_sl_a[k]),
         .i_b  (w_sl_b[k]),
         .i_ci (r_c[k]),
         .o_s  (w_sl_s[k]),
         .o_pg (w_pg[k]),
         .o_gg (w_gg[k])
      );

      assign w_co[k] = w_gg[k] | (w_pg[k] & r_c[k]);
   end

   if (S == 1) begin : g_sum_one
      assign w_sum_raw = w_sl_s[0];
   end else begin : g_sum_many
      assign w_sum_raw = {w_sl_s[S-1], r_as[S-1][WIDTH-GROUP-1:0]};
   end

   // Carry into the MSB is recovered from the MSB's own sum/operand bits.
   assign w_a_msb = r_as[S-1][WIDTH-1];
   assign w_b_msb = r_bt[BT-1];
   assign w_ovf   = w_co[S-1] ^ (w_sum_raw[WIDTH-1] ^ w_a_msb ^ w_b_msb);

`ifdef CLA_SATURATE_EN
   assign w_sum = ~w_ovf   ? w_sum_raw :
                  w_a_msb  ? {1'b1, {(WIDTH-1){1'b0}}} :
                             {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_sum = w_sum_raw;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld_pipe <= '0;
         r_as       <= '0;
         r_bt       <= '0;
         r_c        <= '0;
         r_sum      <= '0;
         r_co       <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
      end else if (w_adv) begin
         r_vld_pipe <= {r_vld_pipe[S-1:0], valid_i};
         if (valid_i) begin
            r_as[0]         <= a_i;
            r_bt[WIDTH-1:0] <= sub_i ? ~b_i : b_i;
            r_c[0]          <= sub_i | ci_i;
         end
         for (int k = 1; k < S; k++) begin
            r_c[k] <= w_co[k-1];
            for (int i = 0; i < WIDTH; i++)
               r_as[k][i] <= ((i / GROUP) == (k - 1)) ? w_sl_s[k-1][i % GROUP] : r_as[k-1][i];
            for (int i = 0; i < WIDTH - k * GROUP; i++)
               r_bt[boff(k) + i] <= r_bt[boff(k-1) + GROUP + i];
         end
         if (r_vld_pipe[S-1]) begin
            r_sum  <= w_sum;
            r_co   <= w_co[S-1];
            r_ovf  <= w_ovf;
            r_zero <= ~|w_sum;
         end
      end
   end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: arithmetic reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_pipelined_cla_addsub;
   localparam int W = 16;
   localparam int G = 4;
   localparam int S = W / G;

   logic         clk = 1'b0;
   logic         rst_i, valid_i, ready_o, ci_i, sub_i, valid_o, ready_i, co_o, ovf_o, zero_o;
   logic [W-1:0] a_i, b_i, sum_o;

   pipelined_cla_addsub #(.WIDTH(W), .GROUP(G)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .a_i(a_i), .b_i(b_i), .ci_i(ci_i), .sub_i(sub_i),
      .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
      .co_o(co_o), .ovf_o(ovf_o), .zero_o(zero_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co;
      logic         ovf;
      logic         zero;
   } res_t;

   int n_checks = 0;
   int n_err = 0;
   int n_consumed = 0;
   bit mon_en = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: true signed result, unsigned result, borrow.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sub);
      res_t   r;
      longint sa, sb, tr, ua, smax, smin;
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
      sb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
      if (sub) begin
         tr   = sa - sb;
         ua   = longint'(a) - longint'(b);
         r.co = (a >= b);
      end else begin
         tr   = sa + sb + longint'(ci);
         ua   = longint'(a) + longint'(b) + longint'(ci);
         r.co = (ua >= (longint'(1) << W));
      end
      r.sum = ua[W-1:0];
      r.ovf = (tr > smax) || (tr < smin);
`ifdef CLA_SATURATE_EN
      if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      r.zero = (r.sum == '0);
      return r;
   endfunction

   // Reference: S-slot delay line that freezes as a whole when the output is held.
   logic mv [0:S];
   res_t md [0:S];
   logic m_adv;
   assign m_adv = !mv[S] || ready_i;

   always @(posedge clk) begin
      if (rst_i) begin
         for (int k = 0; k <= S; k++) mv[k] <= 1'b0;
      end else if (m_adv) begin
         mv[0] <= valid_i;
         md[0] <= model(a_i, b_i, ci_i, sub_i);
         for (int k = 1; k <= S; k++) begin
            mv[k] <= mv[k-1];
            md[k] <= md[k-1];
         end
      end
      if (!rst_i && valid_o === 1'b1 && ready_i) n_consumed <= n_consumed + 1;
   end

   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         chk("mon valid_o", valid_o, mv[S]);
         chk("mon ready_o", ready_o, !mv[S] || ready_i);
         if (mv[S] && valid_o === 1'b1) begin
            chk("mon sum_o", sum_o, md[S].sum);
            chk("mon co_o", co_o, md[S].co);
            chk("mon ovf_o", ovf_o, md[S].ovf);
            chk("mon zero_o", zero_o, md[S].zero);
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
      bit acc;
      int t;
      a_i = a; b_i = b; ci_i = ci; sub_i = sub; valid_i = 1'b1;
      t = 0;
      acc = 0;
      do begin
         #1;
         acc = (ready_o === 1'b1);
         @(negedge clk);
         t++;
      end while (!acc && t < 50);
      if (!acc) begin
         n_checks++;
         n_err++;
         $display("FAIL send timeout: got ready_o=0 for %0d cycles expected acceptance", t);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (valid_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   int           nw, nb, c0;
   logic [W-1:0] cap;

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      a_i = '0; b_i = '0; ci_i = 1'b0; sub_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset valid_o", valid_o, 1'b0);
      chk("reset sum_o", sum_o, 16'h0000);
      chk("reset ready_o", ready_o, 1'b1);
      chk("reset co_o", co_o, 1'b0);
      chk("reset ovf_o", ovf_o, 1'b0);
      chk("reset zero_o", zero_o, 1'b0);
      rst_i = 1'b0;
      mon_en = 1;
      repeat (10) begin
         @(negedge clk);
         chk("idle valid_o", valid_o, 1'b0);
      end

      // Carry crossing group boundaries
      send(16'h00FF, 16'h0001, 1'b0, 1'b0);
      valid_i = 1'b0;
      wait_valid(nw);
      chk("add latency", nw, 4);
      chk("add sum", sum_o, 16'h0100);
      chk("add co", co_o, 1'b0);
      chk("add ovf", ovf_o, 1'b0);
      chk("add zero", zero_o, 1'b0);
      repeat (4) @(negedge clk);

      // Back-to-back subtracts
      send(16'h0005, 16'h0005, 1'b0, 1'b1);
      send(16'h0003, 16'h0005, 1'b1, 1'b1);
      valid_i = 1'b0;
      wait_valid(nw);
      chk("sub1 latency", nw, 3);
      chk("sub1 sum", sum_o, 16'h0000);
      chk("sub1 zero", zero_o, 1'b1);
      chk("sub1 co", co_o, 1'b1);
      chk("sub1 ovf", ovf_o, 1'b0);
      @(negedge clk);
      chk("sub2 valid", valid_o, 1'b1);
      chk("sub2 sum", sum_o, 16'hFFFE);
      chk("sub2 co", co_o, 1'b0);
      chk("sub2 zero", zero_o, 1'b0);
      repeat (4) @(negedge clk);

      // Signed overflow
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      valid_i = 1'b0;
      wait_valid(nw);
      chk("ovf valid", valid_o, 1'b1);
`ifdef CLA_SATURATE_EN
      chk("ovf sum", sum_o, 16'h7FFF);
`else
      chk("ovf sum", sum_o, 16'h8000);
`endif
      chk("ovf flag", ovf_o, 1'b1);
      chk("ovf co", co_o, 1'b0);
      chk("ovf zero", zero_o, 1'b0);
      repeat (4) @(negedge clk);

      // Six operations with a three-cycle output stall
      c0 = n_consumed;
      fork
         begin
            send(16'h1234, 16'h1111, 1'b1, 1'b0);
            send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
            send(16'h8000, 16'h0001, 1'b0, 1'b1);
            send(16'h0010, 16'h0020, 1'b0, 1'b1);
            send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
            send(16'h4000, 16'h4000, 1'b0, 1'b0);
            valid_i = 1'b0;
         end
         begin
            wait_valid(nb);
            chk("stall first valid", valid_o, 1'b1);
            ready_i = 1'b0;
            cap = sum_o;
            repeat (3) begin
               @(negedge clk);
               chk("stall ready_o", ready_o, 1'b0);
               chk("stall valid_o", valid_o, 1'b1);
               chk("stall sum stable", sum_o, cap);
            end
            ready_i = 1'b1;
         end
      join
      repeat (15) @(negedge clk);
      chk("stall results count", n_consumed - c0, 6);

      // Reset with operations in flight; valid_i stays high through the reset edge
      send(16'h0001, 16'h0001, 1'b0, 1'b0);
      send(16'h0002, 16'h0002, 1'b0, 1'b0);
      send(16'h0003, 16'h0003, 1'b0, 1'b0);
      a_i = 16'h0004;
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      valid_i = 1'b0;
      chk("rst valid_o", valid_o, 1'b0);
      chk("rst ready_o", ready_o, 1'b1);
      repeat (10) begin
         @(negedge clk);
         chk("post-rst no output", valid_o, 1'b0);
      end

      send(16'h0001, 16'h0002, 1'b0, 1'b0);
      valid_i = 1'b0;
      wait_valid(nw);
      chk("post-rst latency", nw, 4);
      chk("post-rst sum", sum_o, 16'h0003);
      repeat (6) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the 8-bit two-group CLA adder.
- Operand width is generic.
- Each GROUP-bit lookahead slice occupies one pipeline stage, so carries ripple between stages through registers.
- Adds a subtract mode, signed overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits in the datapath as the shared arithmetic unit feeding the ALU/result bus.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of GROUP and at least GROUP.
GROUP, 4, bits per lookahead slice (one pipeline stage per slice); legal values 2, 4 or 8.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
valid_i  input  1  input operands valid
ready_o  output  1  block can accept an operation this cycle
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
ci_i  input  1  carry-in for add; ignored when sub_i=1
sub_i  input  1  0: A+B+ci_i; 1: A-B (A + ~B + 1)
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result this cycle
sum_o  output  WIDTH  result
co_o  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf_o  output  1  signed two's-complement overflow
zero_o  output  1  sum_o == 0

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Pipeline depth: S = WIDTH/GROUP stages. Stage k (0..S-1) computes bits [k*GROUP +: GROUP].
  - Each slice computes p = a^b and g = a&b per bit.
  - Internal carries come from a full lookahead within the slice: c(j+1) = g(j) | p(j)&c(j), expanded, not rippled.
  - Each slice also produces group P and G. The group carry-out is registered into stage k+1.
- Operand skew: upper operand bits are delayed through skew registers so slice k sees its operand bits in the same cycle as carry k.
  - Lower result bits are delayed through deskew registers so every result bit leaves together.
- Subtract: at acceptance, b is replaced by ~b_i and carry-in is forced to 1.
- Latency: the result appears S cycles after acceptance when there are no stalls. Default is 4 cycles.
- Throughput: 1 operation per cycle.
- Acceptance occurs when valid_i & ready_o are both high at a rising edge.
- Handshake and stall:
  - ready_o = ~valid_o | ready_i (combinational).
  - When valid_o=1 and ready_i=0, the entire pipeline holds. All stage registers, per-stage valid bits and outputs keep their values.
  - sum_o, co_o, ovf_o and zero_o stay stable while valid_o=1 and ready_i=0.
  - valid_i=1 with ready_o=0 is not accepted. The upstream source must hold its data.
- Bubbles: each stage carries a valid bit. An empty slot propagates as a bubble.
  - valid_o falls the cycle after a result is consumed if no operation follows.
  - Back-to-back operations produce valid_o high on consecutive cycles.
- Flags (computed in the last stage, registered with sum_o):
  - co_o is the carry out of bit WIDTH-1.
  - ovf_o = carry into MSB XOR carry out of MSB.
  - zero_o is the NOR of all sum_o bits.
- Wrap-around: sum_o is the result modulo 2^WIDTH; there is no saturation unless the optional feature is enabled.
- Reset:
  - All valid bits clear; sum_o=0, co_o=0, ovf_o=0, zero_o=0, valid_o=0. ready_o=1 follows from valid_o=0.
  - Reset mid-operation discards all in-flight operations; nothing emerges afterwards.
  - Reset has priority over valid_i and ready_i in the same cycle.
- Simultaneous events: acceptance and result consumption in the same cycle are legal. The pipeline advances one slot.

Optional Feature:
CLA_SATURATE_EN
- Defined:
  - When ovf_o=1, sum_o is clamped to the signed limit.
  - If A's sign bit is 0 (positive overflow), sum_o = 0111...1. Otherwise sum_o = 1000...0.
  - ovf_o still reports 1, and zero_o is evaluated on the clamped value.
  - co_o is unaffected.
  - Clamping lives in the final stage and adds no latency.
- Undefined: wrap-around results as described above, and no clamp logic is synthesised.

Test Plan:
- Reset then idle (WIDTH=16, GROUP=4) -> valid_o=0, sum_o=0000, ready_o=1; no output for 10 cycles.
- Add 0x00FF+0x0001, ci_i=0, ready_i=1 -> 4 cycles later valid_o=1, sum_o=0x0100, co_o=0, ovf_o=0, zero_o=0 (carry crosses groups).
- Sub 0x0005-0x0005 then 0x0003-0x0005 back-to-back -> consecutive outputs: sum 0x0000, zero_o=1, co_o=1; then sum 0xFFFE, co_o=0, zero_o=0.
- Add 0x7FFF+0x0001 -> sum_o=0x8000, ovf_o=1, co_o=0; with CLA_SATURATE_EN -> sum_o=0x7FFF, ovf_o=1.
- Stream of 6 operations with ready_i held low for 3 cycles while valid_o=1 -> ready_o=0 during the stall, output stable, no loss or duplication; all 6 results arrive in order.
- Assert rst_i for 1 cycle with 3 operations in flight -> valid_o=0 next cycle and no stale results appear afterwards.
